ber_checker: RTL and testbench
==============================

# ber_checker

Bit-error-rate checker for the 16-QAM modem test system. It is the receive-side counterpart of the I/Q LFSR symbol generators. It takes the transmitted reference symbols and the receiver's sliced symbols, finds the unknown transmit-to-receive pipeline delay by correlation, and then counts bit errors over a fixed measurement window. It sits in the top-level test system beside the receiver, and its results go to the ISSP probes and LEDs.

## Interface
Parameters:
- MAX_DELAY, 32: number of candidate alignment delays, 0..MAX_DELAY-1.
- DLY_W, 5: width of the delay index; equals clog2(MAX_DELAY).
- SEARCH_LEN, 64: symbols compared per candidate delay.
- LOCK_THRESH, 0: maximum symbol mismatches in a search window that still count as lock.
- MEAS_LEN, 1048576: symbols counted per measurement.
- CNT_W, 24: width of the error and symbol counters.

Ports:
- clk, input, 1: system clock (25 MHz).
- reset, input, 1: synchronous, active-low; 0 resets the block on the rising edge of clk.
- sym_clk_ena, input, 1: one-clk-wide symbol strobe from clk_enable_gen.
- start, input, 1: level sampled every clk; a 1 (re)starts alignment and measurement.
- ref_i, ref_q, input, 2 each: transmitted symbols from the LFSRs.
- rx_i, rx_q, input, 2 each: receiver decisions, valid on sym_clk_ena.
- busy, output, 1: high in SEARCH or MEASURE.
- locked, output, 1: high from lock until the next start or reset.
- done, output, 1: high in DONE.
- search_wrap, output, 1: sticky; the search has passed every delay without locking.
- delay, output, DLY_W: current or locked candidate delay.
- bit_errors, output, CNT_W: accumulated bit errors; saturates.
- sym_count, output, CNT_W: symbols measured.

## Operation
- Reference delay line:
  - Holds MAX_DELAY-1 registered 4-bit entries {ref_i, ref_q}.
  - Shifts on every sym_clk_ena, in every state.
  - Tap 0 is the current, unregistered input; tap k is the symbol from k strobes earlier.
  - The compare operand is tap[delay].
- Per-symbol error count: e = popcount({rx_i, rx_q} XOR tap[delay]), range 0..4, computed raw with no Gray mapping. A symbol mismatch means e ≠ 0.
- States: IDLE, SEARCH, MEASURE, DONE.
  - **IDLE**: outputs hold their reset values. start → SEARCH.
  - **SEARCH**:
    - On entry: delay=0, window counter=0, mismatch counter=0, bit_errors=0, sym_count=0, locked=0, search_wrap=0.
    - On each sym_clk_ena: window counter +1; mismatch counter +1 if the symbol mismatched.
    - When the window counter reaches SEARCH_LEN and mismatches ≤ LOCK_THRESH: set locked=1 and go to MEASURE.
    - When the window counter reaches SEARCH_LEN and mismatches > LOCK_THRESH: delay = delay+1, wrapping from MAX_DELAY-1 to 0. The wrap sets search_wrap=1. Both counters clear and searching continues indefinitely.
  - **MEASURE**:
    - On each sym_clk_ena: bit_errors += e, saturating at 2^CNT_W-1; sym_count += 1.
    - When sym_count reaches MEAS_LEN: go to DONE.
    - delay is frozen.
  - **DONE**: results hold, done=1. start → SEARCH.
- start while in SEARCH or MEASURE aborts the current pass and re-enters SEARCH with the entry clears. start held high keeps the block at SEARCH entry.
- The first symbol after a delay change or after entering MEASURE is compared using the new tap. No symbols are discarded.

## Timing
- All registers update on the rising edge of clk. Counters and the delay line advance only on cycles where sym_clk_ena=1.
- reset=0 takes priority over start and sym_clk_ena. After that edge:
  - state=IDLE.
  - All outputs are 0: busy, locked, done, search_wrap, delay, bit_errors, sym_count.
  - The delay line is cleared.
- start=1 is sampled on any clk edge; busy=1 on the following cycle.
- Lock decision, delay increment and the MEASURE→DONE transition are registered on the same edge as the qualifying sym_clk_ena.
- For a true delay D with error-free data, lock is reached after (D+1)·SEARCH_LEN strobes.
- When sym_clk_ena coincides with a window end, that symbol counts in the closing window.
- When start coincides with sym_clk_ena, start wins and that symbol is not counted.
- bit_errors and sym_count are stable outputs from registers, with no combinational path from the inputs.

## Test plan
- **Aligned, error-free.** Setup: rx = ref delayed by 7 strobes, MEAS_LEN=1000. Expected:
  - locked after 512 strobes with delay=7, search_wrap=0.
  - done with bit_errors=0, sym_count=1000.
- **Injected errors.** Setup: delay 7; during MEASURE, flip rx_i[0] every 100th symbol, and flip all 4 bits of one extra symbol. Expected: bit_errors=14, sym_count=1000.
- **Zero delay.** Setup: rx = ref directly. Expected: lock at the end of the first window, delay=0.
- **No correlation.** Setup: rx held at 0 with a nonzero LFSR ref. Expected:
  - never locks.
  - search_wrap=1 after 32·64 strobes.
  - busy stays 1.
- **Reset and restart.** Setup:
  - Assert reset=0 for one clk mid-MEASURE.
  - Later, assert start mid-MEASURE.

  Expected: the reset gives all outputs 0 and IDLE on the next cycle; the start clears counters and sets locked=0 and delay=0.
- **Saturation.** Setup: CNT_W=4, all rx bits inverted after lock. Expected: bit_errors stops at 15 while sym_count keeps incrementing.

Source files
------------

// File: rtl/ber_checker.sv
// 16-QAM bit-error-rate checker: finds the TX-to-RX pipeline delay by correlating
// against a delayed copy of the reference symbols, then counts bit errors over a window.
module ber_checker #(
  parameter int MAX_DELAY   = 32,
  parameter int DLY_W       = 5,
  parameter int SEARCH_LEN  = 64,
  parameter int LOCK_THRESH = 0,
  parameter int MEAS_LEN    = 1048576,
  parameter int CNT_W       = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_clk_ena,
  input  logic             start,
  input  logic [1:0]       ref_i,
  input  logic [1:0]       ref_q,
  input  logic [1:0]       rx_i,
  input  logic [1:0]       rx_q,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic             search_wrap,
  output logic [DLY_W-1:0] delay,
  output logic [CNT_W-1:0] bit_errors,
  output logic [CNT_W-1:0] sym_count,
  output logic [1:0]       dbg_state
);

  localparam int WIN_W = $clog2(SEARCH_LEN + 1);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(SEARCH_LEN - 1);
  localparam logic [WIN_W-1:0] THRESH     = WIN_W'(LOCK_THRESH);
  localparam logic [CNT_W-1:0] MEAS_LAST  = CNT_W'(MEAS_LEN - 1);
  localparam logic [DLY_W-1:0] DLY_LAST   = DLY_W'(MAX_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEARCH  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]       r_dl [MAX_DELAY-1];
  logic [DLY_W-1:0] r_delay;
  logic [WIN_W-1:0] r_win;
  logic [WIN_W-1:0] r_mis;
  logic [CNT_W-1:0] r_be;
  logic [CNT_W-1:0] r_sym;
  logic             r_locked;
  logic             r_wrap;

  logic [3:0]       w_taps [MAX_DELAY];
  logic [3:0]       w_tap;
  logic [3:0]       w_err_vec;
  logic [2:0]       w_e;
  logic             w_mm;
  logic [WIN_W-1:0] w_mis_total;
  logic             w_win_end;
  logic             w_lock_ok;
  logic             w_meas_end;
  logic [CNT_W:0]   w_be_sum;

  // Tap 0 is the live reference input; tap k is the symbol from k strobes ago.
  always_comb begin
    w_taps[0] = {ref_i, ref_q};
    for (int k = 1; k < MAX_DELAY; k++) w_taps[k] = r_dl[k-1];
  end

  assign w_tap       = w_taps[r_delay];
  assign w_err_vec   = {rx_i, rx_q} ^ w_tap;
  assign w_e         = 3'(w_err_vec[0]) + 3'(w_err_vec[1]) + 3'(w_err_vec[2]) + 3'(w_err_vec[3]);
  assign w_mm        = |w_err_vec;
  assign w_mis_total = r_mis + WIN_W'(w_mm);
  assign w_win_end   = sym_clk_ena && (r_win == WIN_LAST);
  assign w_lock_ok   = (w_mis_total <= THRESH);
  assign w_meas_end  = sym_clk_ena && (r_sym == MEAS_LAST);
  assign w_be_sum    = {1'b0, r_be} + (CNT_W+1)'(w_e);

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_SEARCH;
    end else begin
      case (r_state)
        S_SEARCH:  if (w_win_end && w_lock_ok) w_next = S_MEASURE;
        S_MEASURE: if (w_meas_end) w_next = S_DONE;
        default:   w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < MAX_DELAY-1; k++) r_dl[k] <= 4'h0;
      r_delay  <= '0;
      r_win    <= '0;
      r_mis    <= '0;
      r_be     <= '0;
      r_sym    <= '0;
      r_locked <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      if (sym_clk_ena) begin
        r_dl[0] <= {ref_i, ref_q};
        for (int k = 1; k < MAX_DELAY-1; k++) r_dl[k] <= r_dl[k-1];
      end
      // start wins over a coincident strobe: that symbol is dropped from all counters.
      if (start) begin
        r_delay  <= '0;
        r_win    <= '0;
        r_mis    <= '0;
        r_be     <= '0;
        r_sym    <= '0;
        r_locked <= 1'b0;
        r_wrap   <= 1'b0;
      end else begin
        case (r_state)
          S_SEARCH: begin
            if (w_win_end) begin
              r_win <= '0;
              r_mis <= '0;
              if (w_lock_ok) begin
                r_locked <= 1'b1;
              end else if (r_delay == DLY_LAST) begin
                r_delay <= '0;
                r_wrap  <= 1'b1;
              end else begin
                r_delay <= r_delay + 1'b1;
              end
            end else if (sym_clk_ena) begin
              r_win <= r_win + 1'b1;
              r_mis <= w_mis_total;
            end
          end
          S_MEASURE: begin
            if (sym_clk_ena) begin
              r_be  <= w_be_sum[CNT_W] ? {CNT_W{1'b1}} : w_be_sum[CNT_W-1:0];
              r_sym <= r_sym + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy        = (r_state == S_SEARCH) || (r_state == S_MEASURE);
  assign done        = (r_state == S_DONE);
  assign locked      = r_locked;
  assign search_wrap = r_wrap;
  assign delay       = r_delay;
  assign bit_errors  = r_be;
  assign sym_count   = r_sym;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker: directed scenarios (aligned, injected errors, zero delay,
// no correlation, reset/restart, counter saturation) with a lock/done event scoreboard.
module tb_ber_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_s = 1'b0;
  logic        sym_clk_ena = 1'b0;
  logic        start = 1'b0;
  logic        s_start = 1'b0;
  logic [1:0]  ref_i = '0, ref_q = '0, rx_i = '0, rx_q = '0, srx_i = '0, srx_q = '0;

  logic        busy, locked, done, search_wrap;
  logic [4:0]  delay;
  logic [23:0] bit_errors, sym_count;
  logic [1:0]  dbg_state;

  logic        s_busy, s_locked, s_done, s_wrap;
  logic [4:0]  s_delay;
  logic [3:0]  s_be, s_sc;
  logic [1:0]  s_state;

  always #5 clk = ~clk;

  ber_checker #(.MEAS_LEN(1000)) u_dut (
    .clk(clk), .reset(rst_n), .sym_clk_ena(sym_clk_ena), .start(start),
    .ref_i(ref_i), .ref_q(ref_q), .rx_i(rx_i), .rx_q(rx_q),
    .busy(busy), .locked(locked), .done(done), .search_wrap(search_wrap),
    .delay(delay), .bit_errors(bit_errors), .sym_count(sym_count), .dbg_state(dbg_state)
  );

  ber_checker #(.MEAS_LEN(14), .CNT_W(4)) u_sat (
    .clk(clk), .reset(rst_s), .sym_clk_ena(sym_clk_ena), .start(s_start),
    .ref_i(ref_i), .ref_q(ref_q), .rx_i(srx_i), .rx_q(srx_q),
    .busy(s_busy), .locked(s_locked), .done(s_done), .search_wrap(s_wrap),
    .delay(s_delay), .bit_errors(s_be), .sym_count(s_sc), .dbg_state(s_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  int tb_dly = 0;
  int mode = 0;
  logic [15:0] lfsr = 16'hACE1;
  logic [3:0]  hist [0:63];

  // Record: [63:62] kind (1 lock, 2 done), [61:57] delay, [56] wrap,
  // [55:40] strobes since start, [39:16] bit_errors, [15:0] sym_count.
  logic [63:0] exp_q[$];

  function automatic logic [63:0] mk(input logic [1:0] kind, input logic [4:0] d, input logic w,
                                     input int strobes, input int be, input int sc);
    return {kind, d, w, 16'(strobes), 24'(be), 16'(sc)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One symbol every two clocks; rx follows the reference delayed by tb_dly strobes.
  task automatic sym();
    logic [3:0] s, m, r;
    int k;
    @(negedge clk);
    for (int j = 0; j < 4; j++) lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    s = lfsr[3:0];
    for (int j = 63; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = s;
    k = strobe_cnt + 1;
    m = 4'h0;
    if (mode == 1 && k > 512) begin
      if (((k - 512) % 100) == 0) m = 4'b0100;
      if ((k - 512) == 555) m = m ^ 4'hF;
    end
    r = (mode == 2) ? 4'h0 : (hist[tb_dly] ^ m);
    {ref_i, ref_q} = s;
    {rx_i, rx_q} = r;
    {srx_i, srx_q} = (k > 512) ? ~hist[tb_dly] : hist[tb_dly];
    sym_clk_ena = 1'b1;
    @(posedge clk);
    strobe_cnt++;
    @(negedge clk);
    sym_clk_ena = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) sym();
  endtask

  task automatic do_start(input bit sat);
    @(negedge clk);
    if (sat) s_start = 1'b1;
    else     start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_start = 1'b0;
    strobe_cnt = 0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Monitor: every rising edge of locked or done pops one expected record.
  logic prev_locked = 1'b0, prev_done = 1'b0;
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && locked && !prev_locked) begin
        if (exp_q.size() == 0) begin
          check("unexpected_lock", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("lock_kind", 32'd1, 32'(e[63:62]));
          check("lock_delay", 32'(delay), 32'(e[61:57]));
          check("lock_wrap", 32'(search_wrap), 32'(e[56]));
          check("lock_strobes", 32'(strobe_cnt), 32'(e[55:40]));
        end
      end
      if (rst_n && done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", 32'd2, 32'(e[63:62]));
          check("done_bit_errors", 32'(bit_errors), 32'(e[39:16]));
          check("done_sym_count", 32'(sym_count), 32'(e[15:0]));
          check("done_strobes", 32'(strobe_cnt), 32'(e[55:40]));
        end
      end
      prev_locked = locked;
      prev_done = done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int j = 0; j < 64; j++) hist[j] = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wrap", 32'(search_wrap), 0);
    check("rst_delay", 32'(delay), 0);
    check("rst_bit_errors", 32'(bit_errors), 0);
    check("rst_sym_count", 32'(sym_count), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;

    // Aligned, error-free, true delay 7.
    tb_dly = 7; mode = 0;
    exp_q.push_back(mk(2'd1, 5'd7, 1'b0, 512, 0, 0));
    exp_q.push_back(mk(2'd2, 5'd0, 1'b0, 1512, 0, 1000));
    do_start(1'b0);
    check("start_busy", 32'(busy), 1);
    run(511);
    check("pre_lock_locked", 32'(locked), 0);
    check("pre_lock_delay", 32'(delay), 7);
    run(1);
    check("lock_busy", 32'(busy), 1);
    run(1000);
    settle();
    check("aligned_done", 32'(done), 1);
    check("aligned_busy", 32'(busy), 0);
    check("aligned_events", 32'(exp_q.size()), 0);

    // Injected errors: 10 single-bit flips plus one 4-bit flip.
    mode = 1;
    exp_q.push_back(mk(2'd1, 5'd7, 1'b0, 512, 0, 0));
    exp_q.push_back(mk(2'd2, 5'd0, 1'b0, 1512, 14, 1000));
    do_start(1'b0);
    check("restart_from_done_busy", 32'(busy), 1);
    check("restart_from_done_done", 32'(done), 0);
    run(1512);
    settle();
    check("inject_events", 32'(exp_q.size()), 0);

    // Zero delay.
    tb_dly = 0; mode = 0;
    exp_q.push_back(mk(2'd1, 5'd0, 1'b0, 64, 0, 0));
    do_start(1'b0);
    run(64);
    settle();
    check("zero_locked", 32'(locked), 1);
    check("zero_events", 32'(exp_q.size()), 0);
    run(10);
    check("zero_sym_count", 32'(sym_count), 10);
    check("zero_bit_errors", 32'(bit_errors), 0);

    // No correlation: rx held at zero.
    mode = 2;
    do_start(1'b0);
    check("nocorr_start_sym_count", 32'(sym_count), 0);
    check("nocorr_start_locked", 32'(locked), 0);
    run(2047);
    check("nocorr_pre_wrap", 32'(search_wrap), 0);
    check("nocorr_pre_delay", 32'(delay), 31);
    run(1);
    check("nocorr_wrap", 32'(search_wrap), 1);
    check("nocorr_delay", 32'(delay), 0);
    check("nocorr_busy", 32'(busy), 1);
    run(64);
    check("nocorr_still_busy", 32'(busy), 1);
    check("nocorr_locked", 32'(locked), 0);
    check("nocorr_wrap_sticky", 32'(search_wrap), 1);

    // Reset mid-MEASURE.
    tb_dly = 7; mode = 0;
    exp_q.push_back(mk(2'd1, 5'd7, 1'b0, 512, 0, 0));
    do_start(1'b0);
    run(812);
    check("mid_meas_sym_count", 32'(sym_count), 300);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst2_state", 32'(dbg_state), 0);
    check("rst2_busy", 32'(busy), 0);
    check("rst2_locked", 32'(locked), 0);
    check("rst2_delay", 32'(delay), 0);
    check("rst2_sym_count", 32'(sym_count), 0);
    check("rst2_bit_errors", 32'(bit_errors), 0);

    // start mid-MEASURE, then start held across strobes.
    exp_q.push_back(mk(2'd1, 5'd7, 1'b0, 512, 0, 0));
    do_start(1'b0);
    run(812);
    check("mid_meas2_sym_count", 32'(sym_count), 300);
    do_start(1'b0);
    check("abort_locked", 32'(locked), 0);
    check("abort_delay", 32'(delay), 0);
    check("abort_sym_count", 32'(sym_count), 0);
    check("abort_busy", 32'(busy), 1);
    check("abort_events", 32'(exp_q.size()), 0);
    start = 1'b1;
    run(3);
    start = 1'b0;
    @(negedge clk);
    check("held_start_sym_count", 32'(sym_count), 0);
    check("held_start_state", 32'(dbg_state), 1);

    // Saturation on the 4-bit counter instance; main instance parked in reset.
    rst_n = 1'b0;
    rst_s = 1'b1;
    do_start(1'b1);
    run(512);
    check("sat_locked", 32'(s_locked), 1);
    check("sat_delay", 32'(s_delay), 7);
    run(3);
    check("sat_be_12", 32'(s_be), 12);
    run(1);
    check("sat_be_15", 32'(s_be), 15);
    check("sat_sc_4", 32'(s_sc), 4);
    run(2);
    check("sat_be_hold", 32'(s_be), 15);
    check("sat_sc_6", 32'(s_sc), 6);
    run(8);
    check("sat_done", 32'(s_done), 1);
    check("sat_sc_14", 32'(s_sc), 14);
    check("sat_be_final", 32'(s_be), 15);

    settle();
    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
